step_controller: RTL and testbench

Run/step sequencer in front of the CPU core. It turns the raw front-panel `switch` into debounced single-step requests. It gates the core with `cpuEnable` and stretches reset into `cpuReset`. In run mode it can stop the core on a `register1Value` breakpoint. It sits between the board I/O and the `CPU` instance, sharing the CPU's `clock`.

---
 rtl/step_controller.sv | 192 +++++++++++++++++++
 tb/tb_step_controller.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_controller.sv
// step_controller: run/step sequencer in front of the CPU core.
// Optional breakpoint compare and BREAK state: define STEP_BREAKPOINT_EN.
module step_controller #(
    parameter int REGISTER_WIDTH  = 32,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STEP_CYCLES     = 1,
    parameter int RESET_CYCLES    = 4
) (
    input  logic                      clock,
    input  logic                      isReset,
    input  logic                      switch,
    input  logic                      runMode,
    input  logic [REGISTER_WIDTH-1:0] register1Value,
`ifdef STEP_BREAKPOINT_EN
    input  logic [REGISTER_WIDTH-1:0] breakpointValue,
    input  logic                      breakpointEnable,
`endif
    output logic                      cpuEnable,
    output logic                      cpuReset,
    output logic [15:0]               stepCount,
    output logic                      breakHit,
    output logic [2:0]                ctrlState
);

    typedef enum logic [2:0] {
        S_RESET = 3'd0,
        S_HALT  = 3'd1,
        S_STEP  = 3'd2,
        S_RUN   = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    localparam logic [7:0] DB_N      = 8'(DEBOUNCE_CYCLES);
    localparam logic [7:0] STEP_LAST = 8'(STEP_CYCLES - 1);
    localparam logic [7:0] RST_N     = 8'(RESET_CYCLES);

    logic       sync1_q, sync2_q;
    logic       db_q, db_d, db_prev_q;
    logic [7:0] dbcnt_q, dbcnt_d;
    logic       stepReq_q;
    logic       pend_q;
    logic [7:0] cnt_q;
    logic [15:0] stepCount_q;
    logic       cpuEnable_q, cpuReset_q, breakHit_q;
    state_t     state_q;
    logic       bp_trig;

    // Debouncer next state: count disagreeing samples, flip once the count is full
    always_comb begin
        db_d    = db_q;
        dbcnt_d = 8'd0;
        if (sync2_q != db_q) begin
            if (dbcnt_q == DB_N) begin
                db_d    = ~db_q;
                dbcnt_d = 8'd0;
            end else begin
                dbcnt_d = dbcnt_q + 8'd1;
            end
        end
    end

    // Switch synchronizer, debounced level and one-cycle step request pulse
    always_ff @(posedge clock) begin
        if (isReset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
            dbcnt_q   <= 8'd0;
            stepReq_q <= 1'b0;
        end else begin
            sync1_q   <= switch;
            sync2_q   <= sync1_q;
            db_q      <= db_d;
            dbcnt_q   <= dbcnt_d;
            db_prev_q <= db_q;
            stepReq_q <= db_q ^ db_prev_q;
        end
    end

`ifdef STEP_BREAKPOINT_EN
    logic cond, cond_q, bpHit_q;

    assign cond = breakpointEnable && (register1Value == breakpointValue);

    // Rising edge of the match while running; a held match never re-fires
    always_ff @(posedge clock) begin
        if (isReset) begin
            cond_q  <= 1'b0;
            bpHit_q <= 1'b0;
        end else begin
            cond_q  <= cond;
            bpHit_q <= (state_q == S_RUN) && cond && !cond_q;
        end
    end

    assign bp_trig = bpHit_q;
`else
    logic unused_reg;

    assign unused_reg = ^register1Value;
    assign bp_trig    = 1'b0;
`endif

    // Sequencer FSM with registered CPU controls and step bookkeeping
    always_ff @(posedge clock) begin
        if (isReset) begin
            state_q     <= S_RESET;
            cpuReset_q  <= 1'b1;
            cpuEnable_q <= 1'b0;
            breakHit_q  <= 1'b0;
            stepCount_q <= 16'd0;
            cnt_q       <= 8'd0;
            pend_q      <= 1'b0;
        end else begin
            unique case (state_q)
                S_RESET: begin
                    if (stepReq_q) pend_q <= 1'b1;
                    if (cnt_q == RST_N) begin
                        cnt_q      <= 8'd0;
                        cpuReset_q <= 1'b0;
                        if (runMode) begin
                            state_q     <= S_RUN;
                            cpuEnable_q <= 1'b1;
                            pend_q      <= 1'b0;
                        end else begin
                            state_q <= S_HALT;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_HALT: begin
                    if (runMode) begin
                        state_q     <= S_RUN;
                        cpuEnable_q <= 1'b1;
                        pend_q      <= 1'b0;
                    end else if (stepReq_q || pend_q) begin
                        state_q     <= S_STEP;
                        cpuEnable_q <= 1'b1;
                        pend_q      <= 1'b0;
                        cnt_q       <= 8'd0;
                    end
                end
                S_STEP: begin
                    if (stepReq_q) pend_q <= 1'b1;
                    if (cnt_q == STEP_LAST) begin
                        state_q     <= S_HALT;
                        cpuEnable_q <= 1'b0;
                        cnt_q       <= 8'd0;
                        stepCount_q <= stepCount_q + 16'd1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_RUN: begin
                    if (!runMode) begin
                        state_q     <= S_HALT;
                        cpuEnable_q <= 1'b0;
                    end else if (bp_trig) begin
                        state_q     <= S_BREAK;
                        cpuEnable_q <= 1'b0;
                        breakHit_q  <= 1'b1;
                    end
                end
                S_BREAK: begin
                    if (!runMode) begin
                        state_q    <= S_HALT;
                        breakHit_q <= 1'b0;
                    end else if (stepReq_q) begin
                        state_q     <= S_STEP;
                        cpuEnable_q <= 1'b1;
                        breakHit_q  <= 1'b0;
                        cnt_q       <= 8'd0;
                    end
                end
                default: begin
                    state_q     <= S_HALT;
                    cpuEnable_q <= 1'b0;
                    breakHit_q  <= 1'b0;
                end
            endcase
        end
    end

    assign cpuEnable = cpuEnable_q;
    assign cpuReset  = cpuReset_q;
    assign stepCount = stepCount_q;
    assign breakHit  = breakHit_q;
    assign ctrlState = state_q;

endmodule

// File: tb/tb_step_controller.sv
// tb_step_controller: scoreboard bench for step_controller.
// Instance 0 uses default timing; instance 1 uses STEP_CYCLES=8, DEBOUNCE_CYCLES=1.
module tb_step_controller;

    localparam int RW = 8;
    localparam int D0 = 4;
    localparam int S0 = 1;
    localparam int D1 = 1;
    localparam int S1 = 8;

    typedef struct {
        int s;
        int l;
    } win_t;

    logic          clk = 1'b0;
    logic          rst [2];
    logic          sw  [2];
    logic          rm  [2];
    logic [RW-1:0] r1  [2];
    logic [RW-1:0] bpv;
    logic          bpen;
    logic          en  [2];
    logic          crst[2];
    logic [15:0]   cnt [2];
    logic          bh  [2];
    logic [2:0]    st  [2];

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    win_t q0[$];
    win_t q1[$];
    int   wstart[2] = '{0, 0};
    logic pe[2] = '{1'b0, 1'b0};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    step_controller #(
        .REGISTER_WIDTH (RW),
        .DEBOUNCE_CYCLES(D0),
        .STEP_CYCLES    (S0),
        .RESET_CYCLES   (4)
    ) u_dut0 (
        .clock           (clk),
        .isReset         (rst[0]),
        .switch          (sw[0]),
        .runMode         (rm[0]),
        .register1Value  (r1[0]),
`ifdef STEP_BREAKPOINT_EN
        .breakpointValue (bpv),
        .breakpointEnable(bpen),
`endif
        .cpuEnable       (en[0]),
        .cpuReset        (crst[0]),
        .stepCount       (cnt[0]),
        .breakHit        (bh[0]),
        .ctrlState       (st[0])
    );

    step_controller #(
        .REGISTER_WIDTH (RW),
        .DEBOUNCE_CYCLES(D1),
        .STEP_CYCLES    (S1),
        .RESET_CYCLES   (4)
    ) u_dut1 (
        .clock           (clk),
        .isReset         (rst[1]),
        .switch          (sw[1]),
        .runMode         (rm[1]),
        .register1Value  (r1[1]),
`ifdef STEP_BREAKPOINT_EN
        .breakpointValue (bpv),
        .breakpointEnable(bpen),
`endif
        .cpuEnable       (en[1]),
        .cpuReset        (crst[1]),
        .stepCount       (cnt[1]),
        .breakHit        (bh[1]),
        .ctrlState       (st[1])
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int k, input int s, input int l);
        win_t w;
        w.s = s;
        w.l = l;
        if (k == 0) q0.push_back(w);
        else q1.push_back(w);
    endtask

    // Record each cpuEnable window and pop the expected one when it closes
    task automatic mon(input int k);
        win_t w;
        bit   have;
        if (en[k] === 1'b1 && pe[k] !== 1'b1) wstart[k] = cyc;
        if (en[k] !== 1'b1 && pe[k] === 1'b1) begin
            have = (k == 0) ? (q0.size() != 0) : (q1.size() != 0);
            if (!have) begin
                chk($sformatf("win%0d_unexpected_start", k), wstart[k], 32'hFFFF_FFFF);
            end else begin
                if (k == 0) w = q0.pop_front();
                else w = q1.pop_front();
                chk($sformatf("win%0d_start", k), wstart[k], w.s);
                chk($sformatf("win%0d_len", k), cyc - wstart[k], w.l);
            end
        end
        pe[k] = en[k];
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    initial begin
        int c;
        int e;
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1;
            sw[k]  = 1'b0;
            rm[k]  = 1'b0;
            r1[k]  = '0;
        end
        bpv  = RW'(5);
        bpen = 1'b0;

        // reset values
        tick(1);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_crst%0d", k), crst[k], 1);
            chk($sformatf("rst_en%0d", k), en[k], 0);
            chk($sformatf("rst_st%0d", k), st[k], 0);
            chk($sformatf("rst_cnt%0d", k), cnt[k], 0);
            chk($sformatf("rst_bh%0d", k), bh[k], 0);
        end
        tick(2);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        tick(4);
        for (int k = 0; k < 2; k++)
            chk($sformatf("hold_crst%0d", k), crst[k], 1);
        tick(1);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rel_crst%0d", k), crst[k], 0);
            chk($sformatf("rel_st%0d", k), st[k], 1);
            chk($sformatf("rel_en%0d", k), en[k], 0);
            chk($sformatf("rel_cnt%0d", k), cnt[k], 0);
        end

        // single step, default timing
        c = cyc;
        sw[0] = 1'b1;
        push(0, c + 5 + D0, S0);
        tick(20);
        chk("step_cnt", cnt[0], 1);
        chk("step_st", st[0], 1);

        // bounce shorter than the debounce window, then a real toggle
        sw[0] = 1'b0;
        tick(3);
        sw[0] = 1'b1;
        tick(12);
        chk("bounce_cnt", cnt[0], 1);
        c = cyc;
        sw[0] = 1'b0;
        push(0, c + 5 + D0, S0);
        tick(14);
        chk("bounce_step_cnt", cnt[0], 2);

        // two requests inside one long step: one queued, one dropped
        c = cyc;
        sw[1] = 1'b1;
        push(1, c + 5 + D1, S1);
        push(1, c + 5 + D1 + S1 + 1, S1);
        tick(3);
        sw[1] = 1'b0;
        tick(3);
        sw[1] = 1'b1;
        tick(25);
        chk("pend_cnt", cnt[1], 2);
        chk("pend_st", st[1], 1);

        // reset during the third cycle of a step
        c = cyc;
        sw[1] = 1'b0;
        push(1, c + 5 + D1, 3);
        tick(8);
        rst[1] = 1'b1;
        tick(1);
        chk("mid_en", en[1], 0);
        chk("mid_crst", crst[1], 1);
        chk("mid_cnt", cnt[1], 0);
        chk("mid_st", st[1], 0);
        rst[1] = 1'b0;
        tick(8);
        chk("mid_rel_st", st[1], 1);
        chk("mid_rel_crst", crst[1], 0);

        // free run ignores toggles, runMode low returns to HALT
        c = cyc;
        rm[0] = 1'b1;
        tick(1);
        sw[0] = 1'b1;
        tick(12);
        chk("run_st", st[0], 3);
        e = cyc;
        rm[0] = 1'b0;
        push(0, c + 1, e - c);
        tick(4);
        chk("run_halt_st", st[0], 1);
        chk("run_cnt", cnt[0], 2);

`ifdef STEP_BREAKPOINT_EN
        // breakpoint on value 5, then resume with a toggle
        c = cyc;
        r1[0] = '0;
        bpen  = 1'b1;
        rm[0] = 1'b1;
        push(0, c + 1, 6);
        for (int i = 1; i <= 5; i++) begin
            tick(1);
            r1[0] = RW'(i);
        end
        tick(1);
        chk("bp_past_en", en[0], 1);
        chk("bp_past_bh", bh[0], 0);
        tick(1);
        chk("bp_bh", bh[0], 1);
        chk("bp_en", en[0], 0);
        chk("bp_st", st[0], 4);
        tick(3);
        c = cyc;
        sw[0] = 1'b0;
        push(0, c + 5 + D0, S0);
        tick(24);
        chk("resume_st", st[0], 3);
        chk("resume_bh", bh[0], 0);
        chk("resume_cnt", cnt[0], 3);
        e = cyc;
        rm[0] = 1'b0;
        push(0, c + 5 + D0 + S0 + 1, e - (c + 5 + D0 + S0));
        tick(3);
        chk("resume_halt_st", st[0], 1);
`endif

        tick(2);
        chk("q0_left", q0.size(), 0);
        chk("q1_left", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
